// File: rtl/rsi_fsm.sv
// rsi_fsm: Relative Strength Index over PERIOD price differences; optional rolling window (RSI_ROLLING_EN).
// Latency: done/rsi update on the 29th rising edge after the edge that samples the final price.
// Backpressure: none; every new_price in FIRST/ACCUM (and DONE when rolling) is taken in one cycle.
module rsi_fsm #(
    parameter int PERIOD = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] price_in,
    input  logic        new_price,
    output logic        done,
    output logic [7:0]  rsi
);

    localparam int CW        = $clog2(PERIOD + 1);
    localparam int DIV_STEPS = 27;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        ACCUM = 3'd2,
        CALC  = 3'd3,
        DIV   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      count;
    logic [15:0]        prev;
    logic [19:0]        gain_sum;
    logic [19:0]        loss_sum;
    logic [26:0]        num;       // numerator, shifts out MSB-first while quotient bits shift in
    logic [20:0]        den;
    logic [20:0]        rem;
    logic [4:0]         bit_cnt;

    // Signed difference against the reference price and its magnitude
    logic signed [16:0] d;
    logic signed [16:0] d_neg;
    logic [15:0]        d_mag;
    logic [19:0]        add_gain;
    logic [19:0]        add_loss;
    logic [19:0]        sub_gain;
    logic [19:0]        sub_loss;

    // Division step
    logic [21:0]        rem_sh;
    logic [21:0]        rem_sub;
    logic               q_bit;

    // Difference and its split into gain/loss contributions
    always_comb begin
        d        = $signed({1'b0, price_in}) - $signed({1'b0, prev});
        d_neg    = -d;
        d_mag    = d[16] ? d_neg[15:0] : d[15:0];
        add_gain = d[16] ? 20'd0 : {4'd0, d_mag};
        add_loss = d[16] ? {4'd0, d_mag} : 20'd0;
    end

`ifdef RSI_ROLLING_EN
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic signed [16:0] diff_buf [PERIOD];
    logic [PW-1:0]      wr_ptr;
    logic signed [16:0] old_d;
    logic signed [16:0] old_neg;
    logic [15:0]        old_mag;

    // Oldest buffered difference sits at the write pointer once the window is full
    always_comb begin
        old_d    = diff_buf[wr_ptr];
        old_neg  = -old_d;
        old_mag  = old_d[16] ? old_neg[15:0] : old_d[15:0];
        sub_gain = old_d[16] ? 20'd0 : {4'd0, old_mag};
        sub_loss = old_d[16] ? {4'd0, old_mag} : 20'd0;
    end

    // Circular difference buffer, written on every accepted difference
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            for (int i = 0; i < PERIOD; i++) begin
                diff_buf[i] <= '0;
            end
        end else if (start) begin
            wr_ptr <= '0;
        end else if (new_price && (state == ACCUM || state == DONE)) begin
            diff_buf[wr_ptr] <= d;
            wr_ptr           <= (wr_ptr == PW'(PERIOD - 1)) ? '0 : wr_ptr + PW'(1);
        end
    end
`else
    // One-shot mode never retires an old difference
    always_comb begin
        sub_gain = 20'd0;
        sub_loss = 20'd0;
    end
`endif

    // One restoring-division step: bring down the next numerator bit and try to subtract
    always_comb begin
        rem_sh  = {rem, num[26]};
        rem_sub = rem_sh - {1'b0, den};
        q_bit   = (rem_sh >= {1'b0, den});
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start overrides everything including a coincident new_price
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = FIRST;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                FIRST: if (new_price) state_nxt = ACCUM;
                ACCUM: if (new_price && count == CW'(PERIOD - 1)) state_nxt = CALC;
                CALC:  state_nxt = DIV;
                // 27 quotient-bit cycles, then one cycle that registers the result
                DIV:   if (bit_cnt == 5'(DIV_STEPS)) state_nxt = DONE;
`ifdef RSI_ROLLING_EN
                DONE:  if (new_price) state_nxt = CALC;
`else
                DONE:  state_nxt = DONE;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: accumulation, operand setup, division and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done     <= 1'b0;
            rsi      <= 8'd0;
            count    <= '0;
            prev     <= 16'd0;
            gain_sum <= 20'd0;
            loss_sum <= 20'd0;
            num      <= 27'd0;
            den      <= 21'd0;
            rem      <= 21'd0;
            bit_cnt  <= 5'd0;
        end else if (start) begin
            // rsi deliberately survives a restart until the new result lands
            done     <= 1'b0;
            count    <= '0;
            gain_sum <= 20'd0;
            loss_sum <= 20'd0;
        end else begin
            case (state)
                FIRST: begin
                    if (new_price) begin
                        prev <= price_in;
                    end
                end
                ACCUM: begin
                    if (new_price) begin
                        gain_sum <= gain_sum + add_gain;
                        loss_sum <= loss_sum + add_loss;
                        prev     <= price_in;
                        count    <= count + CW'(1);
                    end
                end
                CALC: begin
                    num     <= 27'(gain_sum) * 27'd100;
                    den     <= {1'b0, gain_sum} + {1'b0, loss_sum};
                    rem     <= 21'd0;
                    bit_cnt <= 5'd0;
                end
                DIV: begin
                    if (bit_cnt < 5'(DIV_STEPS)) begin
                        rem     <= q_bit ? rem_sub[20:0] : rem_sh[20:0];
                        num     <= {num[25:0], q_bit};
                        bit_cnt <= bit_cnt + 5'd1;
                    end else begin
                        // Quotient never exceeds 100; a flat window reads as neutral 50
                        rsi  <= (den == 21'd0) ? 8'd50 : num[7:0];
                        done <= 1'b1;
                    end
                end
                DONE: begin
`ifdef RSI_ROLLING_EN
                    if (new_price) begin
                        gain_sum <= gain_sum - sub_gain + add_gain;
                        loss_sum <= loss_sum - sub_loss + add_loss;
                        prev     <= price_in;
                        done     <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsi_fsm.sv
// tb_rsi_fsm: directed bench for rsi_fsm (one-shot build, plus rolling step when RSI_ROLLING_EN is set).
// Latency: expects done/rsi on the 29th rising edge after the final sampled price.
// Backpressure: none; prices are driven back-to-back as single-cycle strobes.
module tb_rsi_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] price_in;
    logic        new_price;
    logic        done;
    logic [7:0]  rsi;

    int n_total = 0;
    int n_pass  = 0;

    localparam int K_ALT  = 0;
    localparam int K_RISE = 1;
    localparam int K_FALL = 2;
    localparam int K_FLAT = 3;
    localparam int K_EXT  = 4;

    rsi_fsm #(.PERIOD(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .price_in  (price_in),
        .new_price (new_price),
        .done      (done),
        .rsi       (rsi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] price_of(input int kind, input int i);
        case (kind)
            K_ALT:   return (i % 2 == 0) ? 16'(100 + i / 2) : 16'(98 + i / 2);
            K_RISE:  return 16'(100 + i);
            K_FALL:  return 16'(114 - i);
            K_FLAT:  return 16'd500;
            default: return (i % 2 == 0) ? 16'd0 : 16'd65535;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // All drive tasks start and end on a falling edge
    task automatic send_price(input logic [15:0] p);
        price_in  = p;
        new_price = 1'b1;
        @(negedge clk);
        new_price = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // pre_edges: rising edges already consumed since the final sampled price
    task automatic wait_result(input int pre_edges, input logic [7:0] exp, input string tag);
        repeat (28 - pre_edges) @(posedge clk);
        #1 check({tag, "_done_edge28"}, 32'(done), 32'd0);
        @(posedge clk);
        #1 check({tag, "_done_edge29"}, 32'(done), 32'd1);
        check({tag, "_rsi"}, 32'(rsi), 32'(exp));
        @(negedge clk);
    endtask

    task automatic run_seq(input int kind, input logic [7:0] exp, input string tag);
        pulse_start();
        for (int i = 0; i < 15; i++) send_price(price_of(kind, i));
        wait_result(0, exp, tag);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        price_in  = 16'd0;
        new_price = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rsi", 32'(rsi), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Alternating -2/+3 pattern, 20 strobes: 16..20 land in CALC/DIV and are ignored
        pulse_start();
        for (int i = 0; i < 20; i++) send_price(price_of(K_ALT, i));
        wait_result(5, 8'd60, "alt20");

`ifdef RSI_ROLLING_EN
        // One more price 30 above the last: window drops an old -2, gains +30
        send_price(16'd137);
        check("roll_done_drop", 32'(done), 32'd0);
        wait_result(0, 8'd80, "roll");
`else
        // Prices after the result are ignored
        for (int i = 0; i < 5; i++) send_price(16'd1000);
        repeat (35) @(negedge clk);
        check("hold_done", 32'(done), 32'd1);
        check("hold_rsi", 32'(rsi), 32'd60);
`endif

        run_seq(K_RISE, 8'd100, "rise");

        // Abort mid-ACCUM; the price coinciding with start must be discarded
        pulse_start();
        for (int i = 0; i < 6; i++) send_price(price_of(K_ALT, i));
        start     = 1'b1;
        new_price = 1'b1;
        price_in  = 16'd999;
        @(negedge clk);
        start     = 1'b0;
        new_price = 1'b0;
        check("abort_done", 32'(done), 32'd0);
        check("abort_rsi_kept", 32'(rsi), 32'd100);
        for (int i = 0; i < 15; i++) send_price(price_of(K_ALT, i));
        wait_result(0, 8'd60, "abort_rerun");

        run_seq(K_FALL, 8'd0, "fall");
        run_seq(K_FLAT, 8'd50, "flat");
        run_seq(K_EXT, 8'd50, "extreme");

        // Reset after the 8th price clears everything immediately
        pulse_start();
        for (int i = 0; i < 8; i++) send_price(price_of(K_ALT, i));
        rst = 1'b0;
        #1;
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rsi", 32'(rsi), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // Prices without a start are ignored in IDLE
        send_price(16'd7);
        send_price(16'd9000);
        run_seq(K_ALT, 8'd60, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
